// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - CPU data-port memory responder with fixed read latency
// One request in flight at a time; req_ready doubles as the pipeline memory stall.
module data_mem_responder #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_mem [2**ADDR_W];

    logic              w_accept;
    logic              w_err;
    logic              w_is_read;
    logic [ADDR_W-1:0] w_req_idx;

    assign w_accept  = req_valid && (r_state == S_IDLE) && !rst;
    assign w_req_idx = req_addr[ADDR_W+1:2];
    assign w_err     = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
    assign w_is_read = (req_wen == 4'b0000);

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = (r_state == S_RESP);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // Only error-free reads with multi-cycle latency need the WAIT state
                    if (w_err || !w_is_read || (RD_LAT == 1)) begin
                        w_next = S_RESP;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_idx     <= '0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_idx <= w_req_idx;
            end

            if (w_accept && (w_next == S_WAIT)) begin
                r_cnt <= 3'(RD_LAT - 1);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end else if (r_state == S_RESP) begin
                r_cnt <= 3'd0;
            end

            // Response fields are loaded only on entry to RESP and held until the next one
            if (w_next == S_RESP) begin
                if (r_state == S_IDLE) begin
                    rsp_err   <= w_err;
                    rsp_rdata <= (w_err || !w_is_read) ? 32'h0 : r_mem[w_req_idx];
                end else begin
                    rsp_err   <= 1'b0;
                    rsp_rdata <= r_mem[r_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && !w_err && !w_is_read) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wen[i]) begin
                    r_mem[w_req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
// Three instances (RD_LAT 1, 2, 4) share request fields; a scoreboard checks every response.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  rdy;
    logic [2:0]  vld;
    logic [2:0]  err;
    logic [2:0]  bsy;
    logic [31:0] rdata [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.ADDR_W(10), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[0]),
        .rsp_valid(vld[0]), .rsp_rdata(rdata[0]), .rsp_err(err[0]), .busy(bsy[0])
    );
    data_mem_responder #(.ADDR_W(10), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[1]),
        .rsp_valid(vld[1]), .rsp_rdata(rdata[1]), .rsp_err(err[1]), .busy(bsy[1])
    );
    data_mem_responder #(.ADDR_W(10), .RD_LAT(4)) u_lat4 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[2]),
        .rsp_valid(vld[2]), .rsp_rdata(rdata[2]), .rsp_err(err[2]), .busy(bsy[2])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (vld[k] === 1'b1) begin
                check("rsp_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    m_e = sb.pop_front();
                    check("rsp_inst",  32'(k),     32'(m_e.inst));
                    check("rsp_rdata", rdata[k],   m_e.rdata);
                    check("rsp_err",   32'(err[k]), 32'(m_e.err));
                    check("rsp_cycle", 32'(cyc),   32'(m_e.due));
                end
            end
        end
    end

    task automatic wait_ready(input int k);
        int n = 0;
        while (rdy[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic wait_done(input int k);
        int n = 0;
        while ((sb.size() != 0 || rdy[k] !== 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic issue(input int k, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err);
        int lat;
        wait_ready(k);
        lat = (exp_err || wen != 4'h0) ? 1 : lat_of(k);
        req_wen      = wen;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid[k] = 1'b1;
        sb.push_back('{k, exp_rdata, exp_err, cyc + lat});
        @(negedge clk);
        req_valid[k] = 1'b0;
        wait_done(k);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        req_valid = 3'b000;
        req_wen   = 4'h0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            check("rst_ready", 32'(rdy[k]), 32'd1);
            check("rst_valid", 32'(vld[k]), 32'd0);
            check("rst_rdata", rdata[k],    32'h0);
            check("rst_err",   32'(err[k]), 32'd0);
            check("rst_busy",  32'(bsy[k]), 32'd0);
        end
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", 32'(rdy[1]), 32'd1);
            check("idle_valid", 32'(vld[1]), 32'd0);
            check("idle_rdata", rdata[1],    32'h0);
        end

        // Full-word write then read
        issue(1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(1, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        repeat (2) @(negedge clk);
        check("hold_rdata", rdata[1],    32'hDEADBEEF);
        check("hold_err",   32'(err[1]), 32'd0);

        // Byte strobes
        issue(1, 4'hF, 32'h20, 32'h11223344, 32'h0, 1'b0);
        issue(1, 4'b0100, 32'h20, 32'h00AA0000, 32'h0, 1'b0);
        issue(1, 4'h0, 32'h20, 32'h0, 32'h11AA3344, 1'b0);

        // Misaligned read and out-of-range write
        issue(1, 4'hF, 32'h0, 32'h0BADF00D, 32'h0, 1'b0);
        issue(1, 4'h0, 32'h22, 32'h0, 32'h0, 1'b1);
        issue(1, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(1, 4'h0, 32'h0, 32'h0, 32'h0BADF00D, 1'b0);

        // Back-to-back reads with req_valid held high, per latency
        for (int k = 0; k < 3; k++) begin
            issue(k, 4'hF, 32'h40, 32'hA5A50000 | 32'(k), 32'h0, 1'b0);
            issue(k, 4'hF, 32'h44, 32'h5A5A0000 | 32'(k), 32'h0, 1'b0);
            req_wen      = 4'h0;
            req_addr     = 32'h40;
            req_valid[k] = 1'b1;
            sb.push_back('{k, 32'hA5A50000 | 32'(k), 1'b0, cyc + lat_of(k)});
            n = 0;
            @(negedge clk);
            while (rdy[k] !== 1'b1 && n < 20) begin
                n++;
                @(negedge clk);
            end
            check("b2b_busy_cycles", 32'(n), 32'(lat_of(k)));
            req_addr = 32'h44;
            sb.push_back('{k, 32'h5A5A0000 | 32'(k), 1'b0, cyc + lat_of(k)});
            @(negedge clk);
            req_valid[k] = 1'b0;
            wait_done(k);
        end

        // Reset during WAIT suppresses the response
        wait_ready(1);
        req_wen      = 4'h0;
        req_addr     = 32'h10;
        req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("midrd_busy", 32'(rdy[1]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrd_valid", 32'(vld[1]), 32'd0);
        check("midrd_ready", 32'(rdy[1]), 32'd1);
        check("midrd_rdata", rdata[1],    32'h0);
        @(negedge clk);
        check("midrd_valid2", 32'(vld[1]), 32'd0);
        check("midrd_ready2", 32'(rdy[1]), 32'd1);

        // Request during reset is ignored and does not write RAM
        rst          = 1'b1;
        req_wen      = 4'hF;
        req_addr     = 32'h10;
        req_wdata    = 32'h12345678;
        req_valid[1] = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        req_valid[1] = 1'b0;
        check("rstreq_ready", 32'(rdy[1]), 32'd1);
        @(negedge clk);
        check("rstreq_valid", 32'(vld[1]), 32'd0);
        issue(1, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the CPU data port. It accepts one load/store request at a time, using byte-lane write strobes in the same format as the datapath's sig_write. It serves the request from an internal word-addressed RAM and returns a single-cycle response after a fixed latency. req_ready drives the pipeline memory stall, so the CPU holds its M stage while a request is in flight.

Parameters:
ADDR_W, 10, word-address bits; RAM depth = 2^ADDR_W words of 32 bits
RD_LAT, 2, read latency in cycles from acceptance to rsp_valid; legal range 1..4

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present this cycle
req_wen  input  4  byte write strobes; bit i writes bits [8i+7:8i]; 4'b0000 = read
req_addr  input  32  byte address
req_wdata  input  32  store data, already lane-aligned by the CPU
req_ready  output  1  responder idle, can accept a request this cycle
rsp_valid  output  1  one-cycle pulse: response for the accepted request
rsp_rdata  output  32  read data; valid only when rsp_valid=1
rsp_err  output  1  request rejected (misaligned or out of range); valid with rsp_valid
busy  output  1  request accepted but not yet responded; equals ~req_ready

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. RAM contents are not reset.
- Acceptance: a request is accepted on the edge where req_valid=1 and req_ready=1. All req_* fields are captured into internal registers at that edge. Request inputs are ignored while req_ready=0.
- Error check, performed at acceptance:
  - err = (req_addr[1:0] != 0) OR (req_addr[31:ADDR_W+2] != 0).
  - An erroring request does not read or write the RAM.
  - It goes to RESP with rsp_err=1 and rsp_rdata=0, for both reads and writes.
- Write (req_wen != 0, no error): enabled bytes are written to RAM[req_addr[ADDR_W+1:2]] at the accept edge; disabled bytes are unchanged. Next state is RESP: rsp_valid=1 in the following cycle with rsp_rdata=0, so write latency is 1.
- Read (req_wen == 0, no error):
  - RD_LAT=1: next state is RESP.
  - RD_LAT>1: next state is WAIT with counter=RD_LAT-1. The counter decrements each cycle in WAIT; move to RESP when the counter reaches 1.
  - rsp_valid=1 exactly RD_LAT cycles after the accept edge. rsp_rdata = the full RAM word at the captured address.
- FSM:
  - IDLE: go to RESP or WAIT on acceptance, otherwise stay in IDLE.
  - WAIT: go to RESP when the counter reaches 1.
  - RESP: always back to IDLE after one cycle.
- req_ready=1 only in IDLE. Maximum throughput is therefore one request per (latency+1) cycles.
- rsp_valid is high for exactly one cycle, in RESP. There is no backpressure; the requester must sample it. rsp_rdata and rsp_err hold their RESP values until the next RESP or reset.
- Read-after-write: a read accepted in any cycle after a write's accept edge returns the written data. There is no same-cycle hazard, since only one request is accepted per cycle.
- Read data must be registered; rsp_rdata has no combinational path from req_*.
- Reset mid-operation: rst in WAIT or RESP forces IDLE on that edge and suppresses any pending rsp_valid. A write already committed to RAM is not undone.
- rst=1 together with req_valid=1: the request is not accepted and the RAM is not written.

Test Plan:
- Reset then idle: after rst, req_ready=1, rsp_valid=0, rsp_rdata=0 → all hold while req_valid=0.
- Full-word write/read, RD_LAT=2:
  - write addr 0x10, wen 4'hF, wdata 0xDEADBEEF → rsp_valid one cycle later, rsp_err=0.
  - read addr 0x10 → rsp_valid exactly 2 cycles after accept, rsp_rdata=0xDEADBEEF.
- Byte strobes: preload 0x11223344 at addr 0x20; write wen 4'b0100, wdata 0x00AA0000 → subsequent read returns 0x11AA3344.
- Errors (ADDR_W=10):
  - read addr 0x22 → rsp_valid after 1 cycle, rsp_err=1, rsp_rdata=0.
  - write addr 0x1000 → rsp_err=1 and RAM word 0 unchanged.
- Busy handling: hold req_valid high across back-to-back reads → second request accepted only after RESP (req_ready low for RD_LAT cycles); sweep RD_LAT over 1, 2 and 4.
- Reset mid-read: accept read, assert rst in the WAIT cycle → no rsp_valid pulse; req_ready=1 the cycle after reset deasserts.
